mac_stream_engine: RTL and testbench

- Memory-mapped fixed-point dot-product engine for neuron evaluation on the SoC data bus. It replaces the single-entry ping-pong B buffer with a B FIFO, and the add-only float datapath with a pipelined signed Q-format multiply-accumulate.
- It adds a bias register, output saturation, and status/overflow reporting.
- The CPU loads vector A once, then streams B weights per neuron and reads one result per neuron.

---
 rtl/mac_stream_pkg.sv | 46 ++++
 rtl/sram.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/mac_stream_engine.sv | 215 +++++++++++++++++++++
 tb/tb_mac_stream_engine.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_stream_pkg.sv
// Shared definitions for the MAC stream engine: bus decode, status layout,
// FSM states and the output saturation helper.
package mac_stream_pkg;

    // Address regions, selected by addr[13:12]
    localparam logic [1:0] REGION_A   = 2'b00;
    localparam logic [1:0] REGION_B   = 2'b01;
    localparam logic [1:0] REGION_RES = 2'b10;
    localparam logic [1:0] REGION_REG = 2'b11;

    // Register word offsets inside REGION_REG, selected by addr[11:2]
    localparam logic [9:0] OFF_LEN    = 10'd0;
    localparam logic [9:0] OFF_CTRL   = 10'd1;
    localparam logic [9:0] OFF_STATUS = 10'd2;
    localparam logic [9:0] OFF_BIAS   = 10'd3;

    // STATUS bit positions
    localparam int ST_VALID_BIT = 0;
    localparam int ST_BUSY_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_SAT_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sram.sv
// Simple dual-port synchronous SRAM: port A read/write, port B read-only.
// Both read ports have one cycle of latency.
module sram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       a_we_i,
    input  logic [$clog2(DEPTH)-1:0]   a_addr_i,
    input  logic [WIDTH-1:0]           a_wdata_i,
    output logic [WIDTH-1:0]           a_rdata_o,
    input  logic [$clog2(DEPTH)-1:0]   b_addr_i,
    output logic [WIDTH-1:0]           b_rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Port A write and registered reads on both ports
    always_ff @(posedge clk_i) begin
        if (a_we_i) mem[a_addr_i] <= a_wdata_i;
        a_rdata_o <= mem[a_addr_i];
        b_rdata_o <= mem[b_addr_i];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output and occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count != '0);
    assign do_push = push_i && ((count != FULL_CNT) || do_pop);

    assign dout_o  = mem[rd_ptr];
    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign count_o = count;

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write
    // NOTE: the storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/mac_stream_engine.sv
// Memory-mapped fixed-point dot-product engine. Vector A lives in an SRAM,
// B weights stream through a FIFO, and a pipelined signed Q-format MAC
// produces one saturated, optionally biased result per neuron.
module mac_stream_engine
    import mac_stream_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DATA_W     = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 40,
    parameter int A_DEPTH    = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            strobe_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            rw_i,
    input  logic [XLEN-1:0] data_i,
    output logic            data_ready_o,
    output logic [XLEN-1:0] data_o,
    output logic            irq_o
);
    localparam int AW     = $clog2(A_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int DCW    = $clog2(MUL_STAGES + 1) + 1;

    // Bus decode
    logic [1:0] region;
    logic [9:0] word;
    logic       unused_bits;
    assign region      = addr_i[13:12];
    assign word        = addr_i[11:2];
    assign unused_bits = ^{addr_i, data_i};

    logic rd_ack_q, rd_from_a_q;
    logic [XLEN-1:0] rd_data_q;
    logic wr, rd_new, len_wr, ctrl_wr, bias_wr, b_push, a_we, res_rd, other_rd;

    assign wr       = strobe_i && rw_i;
    assign rd_new   = strobe_i && !rw_i && !rd_ack_q;
    assign len_wr   = wr && (region == REGION_REG) && (word == OFF_LEN);
    assign ctrl_wr  = wr && (region == REGION_REG) && (word == OFF_CTRL);
    assign bias_wr  = wr && (region == REGION_REG) && (word == OFF_BIAS);
    assign b_push   = wr && (region == REGION_B);
    assign a_we     = wr && (region == REGION_A);
    assign other_rd = rd_new && (region != REGION_RES);

    // State and datapath registers
    state_t state_q, state_d;
    logic                      issue, drain_done;
    logic [AW:0]               len_q, issued_q;
    logic [DCW-1:0]            drain_cnt_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  bias_q, result_q, b_q;
    logic                      bias_en_q, ovf_q, sat_q, valid_q, issue_q;
    logic [MUL_STAGES-1:0]     prod_v_q;
    logic signed [PROD_W-1:0]  prod_q [MUL_STAGES];

    assign res_rd = rd_new && (region == REGION_RES) && valid_q;

    // B FIFO and A buffer
    logic [DATA_W-1:0] fifo_dout, a_cpu_rdata, a_mac_rdata;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (b_push),
        .din_i   (data_i[DATA_W-1:0]),
        .pop_i   (issue),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    sram #(.DEPTH(A_DEPTH), .WIDTH(DATA_W)) u_a_buf (
        .clk_i     (clk_i),
        .a_we_i    (a_we),
        .a_addr_i  (word[AW-1:0]),
        .a_wdata_i (data_i[DATA_W-1:0]),
        .a_rdata_o (a_cpu_rdata),
        .b_addr_i  (issued_q[AW-1:0]),
        .b_rdata_o (a_mac_rdata)
    );

    // Next-state, issue and completion decisions
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE:  if (len_wr) state_d = RUN;
            RUN: begin
                if (len_wr) state_d = RUN;
                else if (issued_q == len_q) state_d = DRAIN;
                else if (!fifo_empty && (issued_q < len_q)) issue = 1'b1;
            end
            DRAIN: begin
                if (len_wr) state_d = RUN;
                else if (drain_cnt_q == DCW'(MUL_STAGES)) begin
                    state_d    = DONE;
                    drain_done = 1'b1;
                end
            end
            DONE:  if (len_wr || res_rd) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Multiplier operands and pipeline data (no reset needed, qualified by valids)
    always_ff @(posedge clk_i) begin
        if (issue) b_q <= fifo_dout;
        prod_q[0] <= PROD_W'($signed(a_mac_rdata)) * PROD_W'(b_q);
        for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end

    // Result of the last multiplier stage, scaled back to Q format and widened
    logic signed [PROD_W-1:0] prod_shifted;
    logic signed [63:0]       biased, clamped;
    assign prod_shifted = prod_q[MUL_STAGES-1] >>> FRAC_BITS;
    assign biased  = 64'(acc_q) + (bias_en_q ? 64'(bias_q) : 64'sd0);
    assign clamped = sat_clamp(biased, DATA_W);

    // Control registers, counters, accumulator and result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q       <= '0;
            bias_q      <= '0;
            bias_en_q   <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            issued_q    <= '0;
            drain_cnt_q <= '0;
            acc_q       <= '0;
            issue_q     <= 1'b0;
            prod_v_q    <= '0;
        end else begin
            if (len_wr)  len_q     <= data_i[AW:0];
            if (bias_wr) bias_q    <= data_i[DATA_W-1:0];
            if (ctrl_wr) bias_en_q <= data_i[0];
            if (ctrl_wr && data_i[1]) begin
                ovf_q <= 1'b0;
                sat_q <= 1'b0;
            end
            if (b_push && fifo_full && !issue) ovf_q <= 1'b1;
            if (drain_done && (clamped != biased)) sat_q <= 1'b1;

            issue_q     <= issue;
            prod_v_q[0] <= issue_q;
            for (int i = 1; i < MUL_STAGES; i++) prod_v_q[i] <= prod_v_q[i-1];
            drain_cnt_q <= (state_q == DRAIN && !len_wr) ? drain_cnt_q + 1'b1 : '0;

            if (len_wr || res_rd) begin
                issued_q <= '0;
                acc_q    <= '0;
                valid_q  <= 1'b0;
                issue_q  <= 1'b0;
                prod_v_q <= '0;
            end else begin
                if (issue) issued_q <= issued_q + 1'b1;
                if (prod_v_q[MUL_STAGES-1]) acc_q <= acc_q + ACC_W'(prod_shifted);
                if (drain_done) begin
                    valid_q  <= 1'b1;
                    result_q <= clamped[DATA_W-1:0];
                end
            end
        end
    end

    // Register-region read data
    logic [XLEN-1:0] reg_rdata;
    always_comb begin
        reg_rdata = '0;
        if (region == REGION_REG && word == OFF_STATUS) begin
            reg_rdata[ST_VALID_BIT]          = valid_q;
            reg_rdata[ST_BUSY_BIT]           = (state_q == RUN) || (state_q == DRAIN);
            reg_rdata[ST_OVF_BIT]            = ovf_q;
            reg_rdata[ST_SAT_BIT]            = sat_q;
            reg_rdata[ST_COUNT_LSB +: CW]    = fifo_count;
        end
    end

    // Read acknowledge and captured read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ack_q    <= 1'b0;
            rd_from_a_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_ack_q    <= res_rd || other_rd;
            rd_from_a_q <= other_rd && (region == REGION_A);
            if (res_rd)        rd_data_q <= XLEN'(result_q);
            else if (other_rd) rd_data_q <= reg_rdata;
        end
    end

    assign data_ready_o = wr || rd_ack_q;
    assign data_o       = rd_from_a_q ? XLEN'($signed(a_cpu_rdata)) : rd_data_q;
    assign irq_o        = valid_q;

endmodule

// File: tb/tb_mac_stream_engine.sv
// Scoreboard bench for mac_stream_engine: read tasks queue expected data,
// a monitor pops and compares whenever a read is acknowledged.
module tb_mac_stream_engine;

    localparam logic [31:0] ADDR_B      = 32'h0000_1000;
    localparam logic [31:0] ADDR_RES    = 32'h0000_2000;
    localparam logic [31:0] ADDR_LEN    = 32'h0000_3000;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_3004;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_3008;
    localparam logic [31:0] ADDR_BIAS   = 32'h0000_300C;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        strobe_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        rw_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        data_ready_o;
    logic [31:0] data_o;
    logic        irq_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk_i = ~clk_i;

    mac_stream_engine dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .strobe_i     (strobe_i),
        .addr_i       (addr_i),
        .rw_i         (rw_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .irq_o        (irq_o)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: compare every acknowledged read against the scoreboard
    initial begin
        string       nm;
        logic [31:0] ex;
        forever begin
            @(negedge clk_i);
            if (strobe_i && !rw_i && data_ready_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_read_ack: got 0x%08h, expected no read", data_o);
                end else begin
                    nm = name_q.pop_front();
                    ex = exp_q.pop_front();
                    check(nm, data_o, ex);
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk_i); #1;
        strobe_i = 1'b1; rw_i = 1'b1; addr_i = addr; data_i = data;
        #1;
        check($sformatf("wr_ack_%08h", addr), 32'(data_ready_o), 32'd1);
        @(posedge clk_i); #1;
        strobe_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] expected,
                            input string name, input bit check_latency);
        int waited;
        exp_q.push_back(expected);
        name_q.push_back(name);
        @(posedge clk_i); #1;
        strobe_i = 1'b1; rw_i = 1'b0; addr_i = addr;
        waited = 0;
        do begin
            @(posedge clk_i); #1;
            waited++;
        end while (!data_ready_o && waited < 500);
        if (!data_ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no ack, expected ack within 500 cycles", name);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end else if (check_latency) begin
            check({name, "_latency"}, 32'(waited), 32'd1);
        end
        @(negedge clk_i);
        @(posedge clk_i); #1;
        strobe_i = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (irq_o !== 1'b1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 32'(irq_o), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; strobe_i = 1'b0; rw_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic push_b3(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        bus_write(ADDR_B, {16'h0, b0});
        bus_write(ADDR_B, {16'h0, b1});
        bus_write(ADDR_B, {16'h0, b2});
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_ready", 32'(data_ready_o), 32'd0);
        check("reset_data_o", data_o, 32'd0);
        bus_read(ADDR_STATUS, 32'h0, "reset_status", 1);

        // Load A and basic dot product with bias disabled
        bus_write(32'h0, 32'h0100);
        bus_write(32'h4, 32'h0200);
        bus_write(32'h8, 32'hFF80);
        bus_read(32'h8, 32'hFFFF_FF80, "a2_sext", 1);
        bus_read(ADDR_LEN, 32'h0, "len_write_only", 1);
        bus_read(ADDR_B, 32'h0, "b_region_read", 1);
        bus_write(ADDR_BIAS, 32'h0100);
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_LEN, 32'd3);
        push_b3(16'h0080, 16'h0040, 16'h0100);
        wait_irq("basic_irq");
        bus_read(ADDR_RES, 32'h0000_0080, "basic_result", 1);
        check("basic_irq_cleared", 32'(irq_o), 32'd0);

        // Bias enabled
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_LEN, 32'd3);
        push_b3(16'h0080, 16'h0040, 16'h0100);
        wait_irq("bias_irq");
        bus_read(ADDR_RES, 32'h0000_0180, "bias_result", 1);

        // Back-to-back neurons: neuron 2 weights queued while neuron 1 is unread
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_LEN, 32'd3);
        push_b3(16'h0080, 16'h0040, 16'h0100);
        wait_irq("n1_irq");
        push_b3(16'h0100, 16'h0100, 16'h0100);
        bus_read(ADDR_STATUS, 32'h0000_0301, "b2b_status", 1);
        bus_read(ADDR_RES, 32'h0000_0080, "n1_result", 1);
        bus_read(ADDR_RES, 32'h0000_0280, "n2_result_stalled", 0);

        // Saturation and sticky clear
        bus_write(32'h0, 32'h7F00);
        bus_write(ADDR_LEN, 32'd1);
        bus_write(ADDR_B, 32'h0200);
        wait_irq("sat_irq");
        bus_read(ADDR_STATUS, 32'h0000_0009, "sat_status", 1);
        bus_read(ADDR_RES, 32'h0000_7FFF, "sat_result", 1);
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_STATUS, 32'h0000_0002, "sat_cleared_status", 1);

        // LEN 0 and FIFO overflow while the result is unread
        bus_write(ADDR_LEN, 32'd0);
        wait_irq("len0_irq");
        for (int i = 0; i < 9; i++) bus_write(ADDR_B, 32'(i + 1));
        bus_read(ADDR_STATUS, 32'h0000_0805, "ovf_status", 1);
        bus_read(ADDR_RES, 32'h0, "len0_result", 1);

        // Reset mid-run after one of three elements
        do_reset();
        bus_write(32'h0, 32'h0100);
        bus_write(ADDR_LEN, 32'd3);
        bus_write(ADDR_B, 32'h0080);
        repeat (6) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("midrun_rst_irq", 32'(irq_o), 32'd0);
        check("midrun_rst_data_o", data_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        bus_read(ADDR_STATUS, 32'h0, "post_rst_status", 1);
        bus_read(32'h4, 32'h0000_0200, "a1_intact", 1);
        bus_read(32'h8, 32'hFFFF_FF80, "a2_intact", 1);
        bus_write(ADDR_LEN, 32'd3);
        push_b3(16'h0080, 16'h0040, 16'h0100);
        wait_irq("rerun_irq");
        bus_read(ADDR_RES, 32'h0000_0080, "rerun_result", 1);

        repeat (5) @(posedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
